store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MemRead  input  1  core load request.
REQ-005 SHALL have port MemWrite  input  1  core store request.
REQ-006 SHALL have port address  input  32  core word address.
REQ-007 SHALL have port write_data  input  32  core store data.
REQ-008 SHALL have port read_data  output  32  load data returned to core.
REQ-009 SHALL have port stall  output  1  store not accepted this cycle; core holds the instruction.
REQ-010 SHALL have port empty  output  1  no entries buffered.
REQ-011 SHALL have port mem_MemRead  output  1  read enable to data memory.
REQ-012 SHALL have port mem_MemWrite  output  1  write enable to data memory.
REQ-013 SHALL have port mem_address  output  32  address to data memory.
REQ-014 SHALL have port mem_write_data  output  32  write data to data memory.
REQ-015 SHALL have port mem_read_data  input  32  combinational read data from data memory.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH {address, data} entries, with head/tail pointers wrapping modulo DEPTH and a count in the range 0..DEPTH.
REQ-017 SHALL define drain = (count != 0) & ~MemRead, meaning the head entry is written to memory this cycle.
REQ-018 SHALL drive during drain: mem_MemWrite=1, mem_address=head address, mem_write_data=head data, and SHALL pop the head at the clock edge.
REQ-019 SHALL drive when MemRead=1: mem_MemRead=1, mem_MemWrite=0, mem_address=address; the load owns the memory port and drain is blocked.
REQ-020 SHALL, when neither load nor drain is active, drive mem_MemRead=0, mem_MemWrite=0, mem_address=0, mem_write_data=0.
REQ-021 SHALL define stall = MemWrite & (count == DEPTH) & ~drain, combinationally.
REQ-022 SHALL push {address, write_data} at the clock edge when MemWrite=1 and stall=0.
REQ-023 SHALL, on simultaneous push and drain, perform both operations, leaving count unchanged; this also applies when count == DEPTH.
REQ-024 SHALL forward on load: read_data = data of the youngest buffered entry whose address equals the load address over all 32 bits; with no match, read_data = mem_read_data.
REQ-025 SHALL drive read_data = 0 when MemRead=0.
REQ-026 SHALL forward only from entries present before the current edge; a same-cycle push is not visible to a same-cycle load.
REQ-027 SHALL, with MemRead and MemWrite both high, serve the load, block drain, and accept the push only if count < DEPTH (otherwise stall=1).
REQ-028 SHALL drive empty = (count == 0), combinationally.
REQ-029 SHALL preserve memory write order equal to store acceptance order; duplicate addresses are drained in order and are not merged.
REQ-030 SHALL give a stored value a minimum latency of 1 cycle from acceptance to memory write (drain on the next non-load cycle).

Reset
REQ-031 SHALL, while rst=1, asynchronously clear count, head and tail to 0, and buffered entries to 0.
REQ-032 SHALL, during reset, drive empty=1, stall=0, and all mem_* outputs to 0; read_data SHALL follow REQ-024/REQ-025 with no matches.
REQ-033 SHALL discard buffered, undrained stores on reset mid-operation; no memory write occurs for them.

Verification
REQ-034 SHALL cover: store addr 17 data 56, then next cycle idle -> that cycle mem_MemWrite=1, mem_address=17, mem_write_data=56; empty=1 afterwards.
REQ-035 SHALL cover: stores (5,10), (5,20) with MemRead held high, then load addr 5 -> read_data=20 (youngest), no memory write issued while MemRead is high.
REQ-036 SHALL cover: 4 stores with MemRead=1 (DEPTH=4), 5th store with MemRead=1 -> stall=1 and count stays 4; drop MemRead -> push and drain in the same cycle, stall=0, count=4.
REQ-037 SHALL cover: load addr 15 with no buffered match and mem_read_data=65 -> read_data=65, mem_MemRead=1, mem_address=15.
REQ-038 SHALL cover: 3 stores buffered, rst pulsed asynchronously between edges -> count=0, empty=1 immediately, no subsequent mem_MemWrite.
REQ-039 SHALL cover: 6 pushes and 6 drains interleaved -> pointer wrap, memory writes in acceptance order.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between core and data memory: queues stores in a circular FIFO, drains them on
// cycles without a load, and forwards the youngest matching buffered store to loads.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        empty,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic full;
  logic drain;
  logic push;

  assign full  = (count_q == CntW'(DEPTH));
  assign drain = (count_q != '0) & ~MemRead;
  assign stall = MemWrite & full & ~drain;
  assign push  = MemWrite & ~stall;
  assign empty = (count_q == '0);

  // Pointer and occupancy bookkeeping; push and drain together leave the count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + PtrW'(1);
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    unique case ({push, drain})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[tail_q] <= address;
      data_q[tail_q] <= write_data;
    end
  end

  // Walk entries oldest to youngest so the last hit is the youngest matching store.
  logic            fwd_hit;
  logic [31:0]     fwd_data;
  logic [PtrW-1:0] fwd_idx;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_q[fwd_idx] == address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (MemRead) begin
      read_data = fwd_hit ? fwd_data : mem_read_data;
    end
  end

  // Memory port: a load owns it, otherwise the head entry drains, otherwise idle zeros.
  always_comb begin
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (MemRead) begin
      mem_MemRead = 1'b1;
      mem_address = address;
    end else if (drain) begin
      mem_MemWrite   = 1'b1;
      mem_address    = addr_q[head_q];
      mem_write_data = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer, checked against a queue-based model of the
// buffered stores.
module tb_store_buffer;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        empty;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  store_buffer #(.DEPTH(Depth)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .stall          (stall),
    .empty          (empty),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  // Each entry is {address, data}; front is the oldest accepted store.
  logic [63:0] sbq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check combinational outputs, then advance
  // the model to what the next rising edge commits.
  task automatic step(input logic mr, input logic mw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] mrd);
    int          cnt;
    bit          drn;
    bit          stl;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    @(negedge clk);
    MemRead       = mr;
    MemWrite      = mw;
    address       = a;
    write_data    = wd;
    mem_read_data = mrd;
    #1;
    cnt = sbq.size();
    drn = (cnt != 0) && !mr;
    stl = mw && (cnt == Depth) && !drn;
    exp_rd = 32'd0;
    if (mr) begin
      exp_rd = mrd;
      foreach (sbq[i]) if (sbq[i][63:32] == a) exp_rd = sbq[i][31:0];
    end
    exp_addr = mr ? a : (drn ? sbq[0][63:32] : 32'd0);
    check_eq("stall", stall, stl);
    check_eq("empty", empty, cnt == 0);
    check_eq("read_data", read_data, exp_rd);
    check_eq("mem_MemRead", mem_MemRead, mr);
    check_eq("mem_MemWrite", mem_MemWrite, drn);
    check_eq("mem_address", mem_address, exp_addr);
    if (!mr) check_eq("mem_write_data", mem_write_data, drn ? sbq[0][31:0] : 32'd0);
    if (drn) void'(sbq.pop_front());
    if (mw && !stl) sbq.push_back({a, wd});
  endtask

  task automatic flush();
    for (int i = 0; i < Depth + 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    address       = '0;
    write_data    = '0;
    mem_read_data = '0;
    #12;
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_mem_we", mem_MemWrite, 1'b0);
    check_eq("rst_mem_addr", mem_address, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single store drains on the following idle cycle.
    step(1'b0, 1'b1, 32'd17, 32'd56, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    check_eq("drain17_addr", mem_address, 32'd17);
    check_eq("drain17_data", mem_write_data, 32'd56);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Youngest duplicate forwarded while loads block draining.
    step(1'b1, 1'b1, 32'd5, 32'd10, 32'd99);
    step(1'b1, 1'b1, 32'd5, 32'd20, 32'd99);
    step(1'b1, 1'b0, 32'd5, 32'd0, 32'd99);
    check_eq("fwd_youngest", read_data, 32'd20);
    flush();

    // Fill under loads, stall on the fifth, then push and drain together at full.
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b1, 32'(100 + i), 32'(i + 1), 32'd0);
    step(1'b1, 1'b1, 32'd200, 32'd7, 32'd0);
    check_eq("full_stall", stall, 1'b1);
    step(1'b1, 1'b1, 32'd200, 32'd7, 32'd0);
    step(1'b0, 1'b1, 32'd200, 32'd7, 32'd0);
    check_eq("full_pushdrain_stall", stall, 1'b0);
    step(1'b1, 1'b1, 32'd201, 32'd8, 32'd0);
    flush();

    // Load miss goes to memory.
    step(1'b1, 1'b0, 32'd15, 32'd0, 32'd65);
    check_eq("miss_read", read_data, 32'd65);

    // Asynchronous reset discards buffered stores.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(40 + i), 32'(i), 32'd0);
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    check_eq("pre_rst_empty", empty, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_empty", empty, 1'b1);
    check_eq("async_rst_mem_we", mem_MemWrite, 1'b0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Interleaved push/drain wraps the pointers.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'(300 + i), 32'(500 + i), 32'd0);
    flush();

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 7)),
           $urandom, $urandom);
    end
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
